// File: rtl/ps2_matrix_pkg.sv
// ps2_matrix_pkg: shared types for the PS/2 to key-matrix converter.
// Holds the map entry layout, FSM states and ps2_key field positions.
package ps2_matrix_pkg;

  typedef struct packed {
    logic       valid;
    logic       lock;
    logic [2:0] row;
    logic [2:0] col;
  } map_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY
  } state_e;

  localparam int KEY_TOG  = 10;
  localparam int KEY_PRS  = 9;
  localparam int KEY_EXT  = 8;
  localparam int CODE_MSB = 7;

endpackage

// File: rtl/ps2_map_ram.sv
// ps2_map_ram: 512x8 simple dual-port map RAM.
// Ports: a_* synchronous read with enable, b_* write only.
module ps2_map_ram (
  input  logic       clk_i,
  input  logic       a_en_i,
  input  logic [8:0] a_addr_i,
  output logic [7:0] a_data_o,
  input  logic       b_we_i,
  input  logic [8:0] b_addr_i,
  input  logic [7:0] b_data_i
);

  logic [7:0] mem_q [512];

  always_ff @(posedge clk_i) begin
    if (b_we_i) mem_q[b_addr_i] <= b_data_i;
  end

  // Read data holds between lookups so APPLY sees the same entry.
  always_ff @(posedge clk_i) begin
    if (a_en_i) a_data_o <= mem_q[a_addr_i];
  end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd: PS/2 key events -> ROWS x COLS key matrix via map RAM.
// In: clk/reset, ps2_key, map write port, ext keys, strobes. Out: col_n, lock, overflow.
module ps2_matrix_kbd
  import ps2_matrix_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int MIN_SCANS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [10:0]          ps2_key_i,
  input  logic                 map_we_i,
  input  logic [8:0]           map_addr_i,
  input  logic [7:0]           map_data_i,
  input  logic [ROWS*COLS-1:0] ext_keys_i,
  input  logic                 all_release_i,
  input  logic [ROWS-1:0]      row_strobe_n_i,
  output logic [COLS-1:0]      col_n_o,
  output logic                 lock_state_o,
  output logic                 overflow_o
);

  localparam int NK = ROWS * COLS;

  state_e     state_q;
  logic       init_q, tog_q, pend_q, ovf_q, prs_q;
  logic [9:0] pend_key_q;
  logic       ev, ram_re, apply, ok;
  logic [7:0] ram_rd;
  map_entry_t ent;

  assign ev     = init_q && (ps2_key_i[KEY_TOG] != tog_q);
  assign ram_re = (state_q == S_IDLE) && pend_q;
  assign apply  = (state_q == S_APPLY);
  assign ent    = map_entry_t'(ram_rd);
  assign ok     = ent.valid && (int'(ent.row) < ROWS)
                  && (int'(ent.col) < COLS);

  ps2_map_ram u_ram (
    .clk_i    (clk_i),
    .a_en_i   (ram_re),
    .a_addr_i ({pend_key_q[KEY_EXT], pend_key_q[CODE_MSB:0]}),
    .a_data_o (ram_rd),
    .b_we_i   (map_we_i),
    .b_addr_i (map_addr_i),
    .b_data_i (map_data_i)
  );

  // The tracker follows bit 10 every cycle; events count only after
  // the first post-reset load so reset never looks like a toggle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      tog_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_key_q <= '0;
      prs_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      init_q <= 1'b1;
      tog_q  <= ps2_key_i[KEY_TOG];
      if (ev) begin
        if (!pend_q || ram_re) begin
          pend_q     <= 1'b1;
          pend_key_q <= ps2_key_i[9:0];
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (ram_re) begin
        pend_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            prs_q   <= pend_key_q[KEY_PRS];
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: state_q <= S_APPLY;
        S_APPLY:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  logic [ROWS-1:0] sync_q [SYNC_STAGES];
  logic [ROWS-1:0] rprev_q, row_s, fall;

  assign row_s = sync_q[SYNC_STAGES-1];
  assign fall  = rprev_q & ~row_s;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      rprev_q <= '1;
    end else begin
      sync_q[0] <= row_strobe_n_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      rprev_q <= row_s;
    end
  end

  logic [NK-1:0] held_q, held_d;
  logic [NK-1:0] str_q, str_d;
  logic [NK-1:0] lock_q, lock_d;
  logic [1:0]    cnt_q [NK];
  logic [1:0]    cnt_d [NK];
  logic [NK-1:0] eff;
  logic [COLS-1:0] col_d, col_q;

  always_comb begin
    held_d = held_q;
    str_d  = str_q;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (str_q[r*COLS+c] && fall[r]) begin
          if (cnt_q[r*COLS+c] != 2'd3)
            cnt_d[r*COLS+c] = cnt_q[r*COLS+c] + 2'd1;
          if (int'(cnt_q[r*COLS+c]) + 1 >= MIN_SCANS)
            str_d[r*COLS+c] = 1'b0;
        end
        if (apply && ok && ent.row == 3'(r) && ent.col == 3'(c)) begin
          if (ent.lock) begin
            if (prs_q) lock_d[r*COLS+c] = ~lock_q[r*COLS+c];
          end else if (prs_q) begin
            held_d[r*COLS+c] = 1'b1;
            str_d[r*COLS+c]  = (MIN_SCANS != 0);
            cnt_d[r*COLS+c]  = 2'd0;
          end else begin
            held_d[r*COLS+c] = 1'b0;
          end
        end
      end
    end
    if (all_release_i) begin
      held_d = '0;
      str_d  = '0;
      for (int i = 0; i < NK; i++) cnt_d[i] = 2'd0;
    end
  end

  assign eff = held_q | str_q | lock_q | ext_keys_i;

  always_comb begin
    col_d = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (eff[r*COLS+c] && !row_s[r]) col_d[c] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      held_q <= '0;
      str_q  <= '0;
      lock_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= 2'd0;
      col_q  <= '1;
    end else begin
      held_q <= held_d;
      str_q  <= str_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
    end
  end

  assign col_n_o      = col_q;
  assign lock_state_o = |lock_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// tb_ps2_matrix_kbd: scoreboard bench for ps2_matrix_kbd.
// A key-level model predicts outputs; a monitor pops and compares.
module tb_ps2_matrix_kbd;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int MINS = 2;
  localparam int NK   = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   ps2 = '0;
  logic          we = 1'b0;
  logic [8:0]    waddr = '0;
  logic [7:0]    wdata = '0;
  logic [NK-1:0] ext = '0;
  logic          arel = 1'b0;
  logic [7:0]    rows_n = 8'hFF;
  logic [7:0]    col_n;
  logic          lck, ovf;

  always #5 clk = ~clk;

  ps2_matrix_kbd #(
    .ROWS(ROWS), .COLS(COLS), .MIN_SCANS(MINS), .SYNC_STAGES(2)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .ps2_key_i      (ps2),
    .map_we_i       (we),
    .map_addr_i     (waddr),
    .map_data_i     (wdata),
    .ext_keys_i     (ext),
    .all_release_i  (arel),
    .row_strobe_n_i (rows_n),
    .col_n_o        (col_n),
    .lock_state_o   (lck),
    .overflow_o     (ovf)
  );

  logic [7:0] mmap [512];
  bit         mset [512];
  bit         held [NK];
  bit         lk   [NK];
  int         need [NK];
  bit         m_ovf = 0;

  typedef struct {
    logic [7:0] col;
    logic       l;
    logic       o;
  } exp_t;

  exp_t  sb [$];
  string sbn [$];
  logic  chk_req = 1'b0;
  int    errors = 0;
  int    checks = 0;

  function automatic logic [7:0] exp_col();
    logic [7:0] v = 8'hFF;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!rows_n[r] && (held[r*COLS+c] || need[r*COLS+c] > 0
            || lk[r*COLS+c] || ext[r*COLS+c]))
          v[c] = 1'b0;
    return v;
  endfunction

  function automatic logic exp_lock();
    logic v = 1'b0;
    for (int k = 0; k < NK; k++) if (lk[k]) v = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_req) begin
      exp_t  e;
      string n;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with empty scoreboard");
      end else begin
        e = sb.pop_front();
        n = sbn.pop_front();
        if ({col_n, lck, ovf} !== {e.col, e.l, e.o}) begin
          errors++;
          $display("FAIL %s: col_n=%h lock=%b ovf=%b, expected col_n=%h lock=%b ovf=%b",
                   n, col_n, lck, ovf, e.col, e.l, e.o);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string n);
    exp_t e;
    e.col = exp_col();
    e.l   = exp_lock();
    e.o   = m_ovf;
    sb.push_back(e);
    sbn.push_back(n);
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  task automatic map_wr(input logic [8:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick(1);
    we = 1'b0;
    mmap[a] = d;
    mset[a] = 1;
  endtask

  task automatic model_ev(input bit p, input logic [8:0] a);
    logic [7:0] e;
    int k;
    if (mset[a]) begin
      e = mmap[a];
      if (e[7] && int'(e[5:3]) < ROWS && int'(e[2:0]) < COLS) begin
        k = int'(e[5:3]) * COLS + int'(e[2:0]);
        if (e[6]) begin
          if (p) lk[k] = !lk[k];
        end else if (p) begin
          held[k] = 1; need[k] = MINS;
        end else begin
          held[k] = 0;
        end
      end
    end
  endtask

  task automatic key_ev(input bit p, input logic [8:0] a, input int w);
    ps2 = {~ps2[10], p, a};
    model_ev(p, a);
    tick(w);
  endtask

  task automatic set_rows(input logic [7:0] v);
    for (int r = 0; r < ROWS; r++)
      if (rows_n[r] && !v[r])
        for (int c = 0; c < COLS; c++)
          if (need[r*COLS+c] > 0) need[r*COLS+c]--;
    rows_n = v;
    tick(6);
  endtask

  task automatic clear_model();
    for (int k = 0; k < NK; k++) begin
      held[k] = 0; need[k] = 0;
    end
  endtask

  logic [8:0] codes [6];

  initial begin
    codes[0] = 9'h01C; codes[1] = 9'h032; codes[2] = 9'h021;
    codes[3] = 9'h058; codes[4] = 9'h07E; codes[5] = 9'h16B;
    for (int k = 0; k < NK; k++) begin
      held[k] = 0; lk[k] = 0; need[k] = 0;
    end
    for (int a = 0; a < 512; a++) mset[a] = 0;
    ps2 = {1'b1, 1'b1, 9'h01C};
    tick(2);
    map_wr(9'h01C, 8'b1_0_101_000);
    map_wr(9'h032, 8'b1_0_000_001);
    map_wr(9'h021, 8'b1_0_011_010);
    map_wr(9'h058, 8'b1_1_100_111);
    map_wr(9'h07E, 8'b0_0_010_010);
    map_wr(9'h16B, 8'b1_0_111_111);
    rst_n = 1'b1;
    tick(2);
    check("reset");

    set_rows(8'hDF);
    check("trk_no_spurious");
    key_ev(1, 9'h01C, 6);
    check("a_press");
    key_ev(0, 9'h01C, 6);
    check("a_release_stretch");
    set_rows(8'hFF);
    set_rows(8'hDF);
    check("a_strobe1");
    set_rows(8'hFF);
    set_rows(8'hDF);
    check("a_strobe2");

    set_rows(8'hFF);
    key_ev(1, 9'h01C, 4);
    key_ev(0, 9'h01C, 5);
    set_rows(8'hDF);
    check("tap_scan1");
    set_rows(8'hFF);
    set_rows(8'hDF);
    check("tap_scan2");

    set_rows(8'hEF);
    key_ev(1, 9'h058, 6);
    check("caps_on");
    key_ev(0, 9'h058, 6);
    check("caps_release");
    key_ev(1, 9'h058, 6);
    check("caps_off");
    key_ev(0, 9'h058, 6);

    ext[0] = 1'b1;
    set_rows(8'hF6);
    check("ext_two_rows");
    key_ev(1, 9'h07E, 6);
    check("unmapped");
    ext = '0;

    key_ev(1, 9'h032, 6);
    key_ev(1, 9'h021, 6);
    check("two_held");
    ps2 = {~ps2[10], 1'b1, 9'h058};
    model_ev(1, 9'h058);
    tick(3);
    arel = 1'b1;
    tick(1);
    arel = 1'b0;
    clear_model();
    tick(4);
    check("arel_vs_lock");
    key_ev(0, 9'h032, 6);
    key_ev(0, 9'h021, 6);
    key_ev(0, 9'h058, 6);

    set_rows(8'hD6);
    ps2 = {~ps2[10], 1'b1, 9'h032};
    model_ev(1, 9'h032);
    tick(1);
    ps2 = {~ps2[10], 1'b1, 9'h021};
    model_ev(1, 9'h021);
    tick(1);
    ps2 = {~ps2[10], 1'b1, 9'h01C};
    m_ovf = 1;
    tick(8);
    check("ovf_drop");
    key_ev(0, 9'h032, 6);
    key_ev(0, 9'h021, 6);
    check("ovf_sticky");
    arel = 1'b1;
    tick(1);
    arel = 1'b0;
    clear_model();
    tick(4);
    check("all_release");

    for (int i = 0; i < 80; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        key_ev(1'($urandom_range(0, 1)), codes[$urandom_range(0, 5)], 6);
      end else if (op <= 6) begin
        set_rows(8'($urandom_range(0, 255)));
      end else if (op == 7) begin
        if ($urandom_range(0, 1) == 1)
          ext = NK'(1) << $urandom_range(0, NK-1);
        else
          ext = '0;
        tick(4);
      end else begin
        arel = 1'b1;
        tick(1);
        arel = 1'b0;
        clear_model();
        tick(4);
      end
      check($sformatf("rnd%0d", i));
    end

    tick(4);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
